// File: rtl/bcd_para_binario_pkg.sv
// bcd_para_binario_pkg
// Shared definitions for the BCD-to-binary converter:
//   - FSM state encoding (OCIOSO, CONVERTE, CONCLUI)
//   - reverse double-dabble correction constants (threshold 8, offset 3)
//   - largest legal BCD digit (9) and a per-nibble validity helper
package bcd_para_binario_pkg;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    CONVERTE = 2'd1,
    CONCLUI  = 2'd2
  } estado_t;

  localparam logic [3:0] LIMIAR       = 4'd8;
  localparam logic [3:0] DESLOCAMENTO = 4'd3;
  localparam logic [3:0] DIGITO_MAX   = 4'd9;

  function automatic logic digito_invalido(input logic [3:0] d);
    return (d > DIGITO_MAX);
  endfunction

endpackage

// File: rtl/bcd_para_binario_corrige_digito.sv
// corrige_digito
// Combinational nibble corrector for reverse double-dabble: after the
// right shift, a BCD nibble that reached 8 or more holds a carried-in
// weight of 8 that should have been 5, so 3 is subtracted.
// Ports:
//   d - nibble after the shift
//   q - corrected nibble
module corrige_digito
  import bcd_para_binario_pkg::*;
(
  input  logic [3:0] d,
  output logic [3:0] q
);

  assign q = (d >= LIMIAR) ? (d - DESLOCAMENTO) : d;

endmodule

// File: rtl/bcd_para_binario.sv
// bcd_para_binario
// Sequential BCD-to-binary converter (reverse double-dabble), one bit-step
// per clock, with inicio/ocupado/pronto handshake.
// Optional feature: define BCD_VALIDA_EN to reject requests that carry a
// nibble above 9 (erro=1, binario=0, pronto on the cycle after acceptance).
// Without it erro stays 0 and every nibble is run through the algorithm.
// Parameters:
//   DIGITOS - number of BCD input digits
//   BITS    - result width, also the number of conversion steps
// Ports:
//   clk     - system clock, rising edge
//   rst_n   - synchronous active-low reset
//   inicio  - start request, only looked at while idle
//   bcd_in  - packed BCD digits, MSD in the top nibble
//   binario - registered result, held until the next result
//   pronto  - one-cycle pulse: binario/erro are new
//   ocupado - request in flight
//   erro    - invalid digit flag, valid with pronto and held
//
// state    | meaning
// OCIOSO   | idle, waiting for inicio
// CONVERTE | one shift/correct step per cycle, BITS steps
// CONCLUI  | pronto high for one cycle, then back to idle
module bcd_para_binario
  import bcd_para_binario_pkg::*;
#(
  parameter int DIGITOS = 2,
  parameter int BITS    = 7
)(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inicio,
  input  logic [4*DIGITOS-1:0] bcd_in,
  output logic [BITS-1:0]      binario,
  output logic                 pronto,
  output logic                 ocupado,
  output logic                 erro
);

  localparam int W  = 4*DIGITOS + BITS;
  localparam int CW = $clog2(BITS + 1);
  localparam logic [CW-1:0] ULTIMO = CW'(BITS - 1);

  estado_t         estado, estado_prox;
  logic [W-1:0]    desl, desl_prox;
  logic [W-1:0]    deslocado, corrigido;
  logic [CW-1:0]   cont, cont_prox;
  logic [BITS-1:0] binario_q, binario_prox;
  logic            erro_q, erro_prox;
  logic            invalido;

  // Shift step: the binary field just takes the shifted bits; only the
  // nibbles of the BCD field get corrected.
  assign deslocado = desl >> 1;
  assign corrigido[BITS-1:0] = deslocado[BITS-1:0];

  for (genvar g = 0; g < DIGITOS; g++) begin : g_corr
    corrige_digito u_corr (
      .d (deslocado[BITS+4*g +: 4]),
      .q (corrigido[BITS+4*g +: 4])
    );
  end

`ifdef BCD_VALIDA_EN
  always_comb begin
    invalido = 1'b0;
    for (int i = 0; i < DIGITOS; i++) begin
      if (digito_invalido(bcd_in[4*i +: 4])) invalido = 1'b1;
    end
  end
`else
  assign invalido = 1'b0;
`endif

  always_comb begin
    estado_prox  = estado;
    desl_prox    = desl;
    cont_prox    = cont;
    binario_prox = binario_q;
    erro_prox    = erro_q;
    case (estado)
      OCIOSO: begin
        if (inicio) begin
          desl_prox = {bcd_in, {BITS{1'b0}}};
          cont_prox = '0;
          erro_prox = invalido;
          if (invalido) begin
            binario_prox = '0;
            estado_prox  = CONCLUI;
          end else begin
            estado_prox = CONVERTE;
          end
        end
      end
      CONVERTE: begin
        desl_prox = corrigido;
        cont_prox = cont + CW'(1);
        // cont holds the number of steps already done; this edge is the last
        if (cont == ULTIMO) begin
          binario_prox = corrigido[BITS-1:0];
          estado_prox  = CONCLUI;
        end
      end
      CONCLUI: estado_prox = OCIOSO;
      default: estado_prox = OCIOSO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado    <= OCIOSO;
      desl      <= '0;
      cont      <= '0;
      binario_q <= '0;
      erro_q    <= 1'b0;
    end else begin
      estado    <= estado_prox;
      desl      <= desl_prox;
      cont      <= cont_prox;
      binario_q <= binario_prox;
      erro_q    <= erro_prox;
    end
  end

  assign binario = binario_q;
  assign erro    = erro_q;
  assign pronto  = (estado == CONCLUI);
  assign ocupado = (estado != OCIOSO);

endmodule

// File: tb/tb_bcd_para_binario.sv
module tb_bcd_para_binario;

  localparam int BITS  = 7;
  localparam int BITS3 = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inicio;
  logic [7:0]  bcd_in;
  logic [6:0]  binario;
  logic        pronto, ocupado, erro;

  logic        inicio3;
  logic [11:0] bcd_in3;
  logic [9:0]  binario3;
  logic        pronto3, ocupado3, erro3;

  bcd_para_binario #(.DIGITOS(2), .BITS(BITS)) u_dut (
    .clk(clk), .rst_n(rst_n), .inicio(inicio), .bcd_in(bcd_in),
    .binario(binario), .pronto(pronto), .ocupado(ocupado), .erro(erro)
  );

  bcd_para_binario #(.DIGITOS(3), .BITS(BITS3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .inicio(inicio3), .bcd_in(bcd_in3),
    .binario(binario3), .pronto(pronto3), .ocupado(ocupado3), .erro(erro3)
  );

  always #5 clk = ~clk;

  int ciclo = 0;
  always @(posedge clk) ciclo <= ciclo + 1;

  typedef struct {
    int bin;
    int err;
    int ed;   // posedge index after which pronto must be high
  } esp_t;

  esp_t fila[$];
  int   hist[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic pronto_ant = 1'b0;

  task automatic chk(input string nome, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nome, act, exp, $time);
    end
  endtask

  // Reference: decimal value of the digits. Error path only exists with
  // the validation feature; otherwise the bench only issues legal digits.
  function automatic esp_t modelo(input logic [11:0] v, input int nd,
                                  input int acc, input int bits);
    esp_t e;
    int s = 0;
    int inv = 0;
    for (int i = nd - 1; i >= 0; i--) begin
      int d;
      d = int'((v >> (4 * i)) & 12'hF);
      if (d > 9) inv = 1;
      s = s * 10 + d;
    end
`ifdef BCD_VALIDA_EN
    if (inv != 0) begin
      e.bin = 0; e.err = 1; e.ed = acc;
      return e;
    end
`endif
    e.bin = s; e.err = 0; e.ed = acc + bits;
    return e;
  endfunction

  function automatic logic [11:0] gerar(input int nd);
    logic [11:0] v = '0;
    for (int i = 0; i < nd; i++) begin
      logic [3:0] d;
      d = 4'($urandom_range(0, 9));
`ifdef BCD_VALIDA_EN
      if ($urandom_range(0, 7) == 0) d = 4'($urandom_range(10, 15));
`endif
      v = v | (12'(d) << (4 * i));
    end
    return v;
  endfunction

  // Monitor: every pronto pops one expectation.
  always @(negedge clk) begin
    if (rst_n && pronto) begin
      esp_t e;
      chk("pronto_largura", int'(pronto_ant), 0);
      if (fila.size() == 0) begin
        chk("pronto_inesperado", 1, 0);
      end else begin
        e = fila.pop_front();
        chk("binario", int'(binario), e.bin);
        chk("erro", int'(erro), e.err);
        chk("latencia", ciclo, e.ed);
        hist.push_back(ciclo);
      end
    end
    pronto_ant = rst_n && pronto;
  end

  task automatic espera_ocioso();
    int n = 0;
    @(negedge clk);
    while (ocupado && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("timeout_ocioso", 1, 0);
  endtask

  task automatic espera_fim();
    int n = 0;
    while ((fila.size() != 0 || ocupado) && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("timeout_fim", 1, 0);
  endtask

  task automatic req(input logic [7:0] v);
    espera_ocioso();
    bcd_in = v;
    inicio = 1'b1;
    fila.push_back(modelo({4'h0, v}, 2, ciclo + 1, BITS));
    @(negedge clk);
    inicio = 1'b0;
    chk("ocupado_sobe", int'(ocupado), 1);
  endtask

  task automatic req3(input logic [11:0] v);
    esp_t e;
    int n = 0;
    while (ocupado3 && n < 100) begin @(negedge clk); n++; end
    bcd_in3 = v;
    inicio3 = 1'b1;
    e = modelo(v, 3, ciclo + 1, BITS3);
    @(negedge clk);
    inicio3 = 1'b0;
    n = 0;
    while (!pronto3 && n < 30) begin @(negedge clk); n++; end
    chk("timeout_pronto3", int'(pronto3), 1);
    chk("binario3", int'(binario3), e.bin);
    chk("erro3", int'(erro3), e.err);
    chk("latencia3", ciclo, e.ed);
    @(negedge clk);
    chk("pronto3_largura", int'(pronto3), 0);
  endtask

  initial begin
    int a1;
    int n;
    rst_n = 1'b0; inicio = 1'b0; bcd_in = '0;
    inicio3 = 1'b0; bcd_in3 = '0;
    repeat (3) @(negedge clk);
    chk("rst_binario", int'(binario), 0);
    chk("rst_pronto", int'(pronto), 0);
    chk("rst_ocupado", int'(ocupado), 0);
    chk("rst_erro", int'(erro), 0);
    rst_n = 1'b1;

    req(8'h42);
    espera_fim();
    req(8'h99);
    espera_fim();
    req(8'h00);
    espera_fim();

    // inicio held high across two requests
    espera_ocioso();
    bcd_in = 8'h15;
    inicio = 1'b1;
    a1 = ciclo + 1;
    fila.push_back(modelo(12'h015, 2, a1, BITS));
    @(negedge clk);
    bcd_in = 8'h37;
    fila.push_back(modelo(12'h037, 2, a1 + BITS + 2, BITS));
    n = 0;
    while (ciclo < a1 + BITS + 2 && n < 50) begin @(negedge clk); n++; end
    inicio = 1'b0;
    espera_fim();
    if (hist.size() >= 2) chk("espacamento", hist[hist.size()-1] - hist[hist.size()-2], BITS + 2);
    else chk("espacamento_falta", int'(hist.size()), 2);

    // reset at step 3 of an 8'h88 conversion; no pronto may follow
    espera_ocioso();
    bcd_in = 8'h88;
    inicio = 1'b1;
    a1 = ciclo + 1;
    @(negedge clk);
    inicio = 1'b0;
    while (ciclo < a1 + 3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_binario", int'(binario), 0);
    chk("abort_pronto", int'(pronto), 0);
    chk("abort_ocupado", int'(ocupado), 0);
    chk("abort_erro", int'(erro), 0);
    repeat (BITS + 3) @(negedge clk);
    req(8'h21);
    espera_fim();

`ifdef BCD_VALIDA_EN
    req(8'h5A);
    espera_fim();
    req(8'h56);
    espera_fim();
`endif

    for (int i = 0; i < 30; i++) begin
      logic [11:0] v;
      v = gerar(2);
      req(v[7:0]);
    end
    espera_fim();

    req3(12'h999);
    for (int i = 0; i < 6; i++) req3(gerar(3));

    chk("fila_vazia", fila.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
